pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with soft-start/soft-stop duty ramping and a latched fault state.
// Duty only moves at period boundaries. A fault forces the output low in the same cycle.
module pwm_ramp_ctrl #(
  parameter int PERIOD       = 10,
  parameter int STEP_PERIODS = 2,
  parameter int DW           = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          tgt_valid,
  input  logic [DW-1:0] tgt_duty,
  output logic          tgt_ready,
  input  logic          fault,
  input  logic          fault_clr,
  output logic [DW-1:0] duty,
  output logic          pwm_out,
  output logic          busy,
  output logic          at_target
);

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [DW-1:0] PERIOD_C  = DW'(PERIOD);
  localparam logic [DW-1:0] LAST_CNT  = DW'(PERIOD - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEP_PERIODS - 1);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RUN   = 3'd1,
    S_RAMP  = 3'd2,
    S_STOP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          busy_q, busy_d;
  logic          at_target_q, at_target_d;

  logic          active_s;
  logic          period_end_s;
  logic          accept_s;
  logic [DW-1:0] tgt_clamp_s;
  logic [DW-1:0] toward_s;

  assign active_s     = (state_q == S_RUN) || (state_q == S_RAMP) || (state_q == S_STOP);
  assign period_end_s = (cnt_q == LAST_CNT);
  assign tgt_ready    = (state_q != S_FAULT);
  assign accept_s     = tgt_valid && tgt_ready;
  assign tgt_clamp_s  = (tgt_duty > PERIOD_C) ? PERIOD_C : tgt_duty;

  // The output compares the counter against the applied duty. Fault gates it directly so shutdown needs no clock edge.
  assign pwm_out   = active_s && (cnt_q < duty_q) && !fault;
  assign duty      = duty_q;
  assign busy      = busy_q;
  assign at_target = at_target_q;

  // One-count move of the duty toward the stored target.
  always_comb begin
    if (duty_q < tgt_q) begin
      toward_s = duty_q + DW'(1);
    end else if (duty_q > tgt_q) begin
      toward_s = duty_q - DW'(1);
    end else begin
      toward_s = duty_q;
    end
  end

  // Next-state logic. Fault overrides everything and clears the working state.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    duty_d  = duty_q;

    if (active_s) begin
      cnt_d = period_end_s ? DW'(0) : (cnt_q + DW'(1));
    end else begin
      cnt_d = DW'(0);
    end

    if (accept_s) begin
      tgt_d = tgt_clamp_s;
    end else begin
      tgt_d = tgt_q;
    end

    case (state_q)
      S_OFF: begin
        duty_d = DW'(0);
        sc_d   = SW'(0);
        if (enable) begin
          state_d = (tgt_q != DW'(0)) ? S_RAMP : S_RUN;
        end else begin
          state_d = S_OFF;
        end
      end
      S_RUN: begin
        sc_d = SW'(0);
        if (!enable) begin
          state_d = S_STOP;
        end else if (tgt_q != duty_q) begin
          state_d = S_RAMP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RAMP: begin
        if (!enable) begin
          state_d = S_STOP;
          sc_d    = SW'(0);
        end else if (period_end_s && (sc_q == LAST_STEP)) begin
          sc_d    = SW'(0);
          duty_d  = toward_s;
          state_d = (toward_s == tgt_q) ? S_RUN : S_RAMP;
        end else if (period_end_s) begin
          sc_d = sc_q + SW'(1);
        end else begin
          sc_d = sc_q;
        end
      end
      S_STOP: begin
        if (enable) begin
          state_d = S_RAMP;
          sc_d    = SW'(0);
        end else if (period_end_s && (duty_q == DW'(0))) begin
          state_d = S_OFF;
          sc_d    = SW'(0);
        end else if (period_end_s && (sc_q == LAST_STEP)) begin
          duty_d = duty_q - DW'(1);
          sc_d   = SW'(0);
        end else if (period_end_s) begin
          sc_d = sc_q + SW'(1);
        end else begin
          sc_d = sc_q;
        end
      end
      S_FAULT: begin
        duty_d = DW'(0);
        sc_d   = SW'(0);
        tgt_d  = DW'(0);
        if (fault_clr && !fault) begin
          state_d = S_OFF;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_OFF;
        duty_d  = DW'(0);
        sc_d    = SW'(0);
      end
    endcase

    if (fault) begin
      state_d = S_FAULT;
      cnt_d   = DW'(0);
      sc_d    = SW'(0);
      tgt_d   = DW'(0);
      duty_d  = DW'(0);
    end else begin
      state_d = state_d;
    end

    busy_d      = (state_d == S_RAMP) || (state_d == S_STOP);
    at_target_d = (state_d == S_RUN);
  end

  // State and status registers with asynchronous reset to OFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_OFF;
      cnt_q       <= DW'(0);
      sc_q        <= SW'(0);
      tgt_q       <= DW'(0);
      duty_q      <= DW'(0);
      busy_q      <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sc_q        <= sc_d;
      tgt_q       <= tgt_d;
      duty_q      <= duty_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: table of {inputs, cycles, expected outputs} plus hand sequences.
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       tgt_valid;
  logic [3:0] tgt_duty;
  logic       tgt_ready;
  logic       fault;
  logic       fault_clr;
  logic [3:0] duty;
  logic       pwm_out;
  logic       busy;
  logic       at_target;

  int checks = 0;
  int errors = 0;

  pwm_ramp_ctrl #(.PERIOD(10), .STEP_PERIODS(2), .DW(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .tgt_valid (tgt_valid),
    .tgt_duty  (tgt_duty),
    .tgt_ready (tgt_ready),
    .fault     (fault),
    .fault_clr (fault_clr),
    .duty      (duty),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .at_target (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [3:0] tgt;
    logic       flt;
    logic       clr;
    int         ncyc;
    logic [3:0] e_duty;
    logic       e_pwm;
    logic       e_busy;
    logic       e_at;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic vld, input logic [3:0] tgt,
                     input logic flt, input logic clr, input int ncyc,
                     input logic [3:0] e_duty, input logic e_pwm, input logic e_busy,
                     input logic e_at, input logic e_rdy);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.tgt = tgt; v.flt = flt; v.clr = clr; v.ncyc = ncyc;
    v.e_duty = e_duty; v.e_pwm = e_pwm; v.e_busy = e_busy; v.e_at = e_at; v.e_rdy = e_rdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    tgt_valid = 1'b0;
    tgt_duty  = 4'd0;
    fault     = 1'b0;
    fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Reset, accept target n while disabled, enable; ends in RUN at duty n with cnt 0.
  task automatic ramp_to(input logic [3:0] n);
    do_reset();
    tgt_valid = 1'b1;
    tgt_duty  = n;
    tick();
    tgt_valid = 1'b0;
    enable    = 1'b1;
    repeat (1 + 20 * int'(n)) tick();
  endtask

  initial begin
    int ones;
    do_reset();

    //   rst en vld tgt flt clr  n   duty pwm busy at rdy
    // reset values
    add(1, 0, 0, 4'd0, 0, 0,   0,  4'd0, 0, 0, 0, 1);
    // ramp 0 -> 3, one count per 20 cycles
    add(1, 0, 1, 4'd3, 0, 0,   1,  4'd0, 0, 0, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd0, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  19,  4'd0, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd1, 1, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  20,  4'd2, 1, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  19,  4'd2, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd3, 1, 0, 1, 1);
    // RUN at 5, request 15 clamps to 10
    add(1, 0, 1, 4'd5, 0, 0,   1,  4'd0, 0, 0, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd0, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0, 100,  4'd5, 1, 0, 1, 1);
    add(0, 1, 1, 4'd15,0, 0,   1,  4'd5, 1, 0, 1, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd5, 1, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  17,  4'd5, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd6, 1, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  80,  4'd10,1, 0, 1, 1);
    add(0, 1, 0, 4'd0, 0, 0,  25,  4'd10,1, 0, 1, 1);
    // RUN at 6, soft stop to OFF
    add(1, 0, 1, 4'd6, 0, 0,   1,  4'd0, 0, 0, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd0, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0, 120,  4'd6, 1, 0, 1, 1);
    add(0, 0, 0, 4'd0, 0, 0,   1,  4'd6, 1, 1, 0, 1);
    add(0, 0, 0, 4'd0, 0, 0,  18,  4'd6, 0, 1, 0, 1);
    add(0, 0, 0, 4'd0, 0, 0,   1,  4'd5, 1, 1, 0, 1);
    add(0, 0, 0, 4'd0, 0, 0, 100,  4'd0, 0, 1, 0, 1);
    add(0, 0, 0, 4'd0, 0, 0,   9,  4'd0, 0, 1, 0, 1);
    add(0, 0, 0, 4'd0, 0, 0,   1,  4'd0, 0, 0, 0, 1);
    // fault mid-ramp at duty 4, cnt 2
    add(1, 0, 1, 4'd8, 0, 0,   1,  4'd0, 0, 0, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd0, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  82,  4'd4, 1, 1, 0, 1);
    add(0, 1, 0, 4'd0, 1, 0,   0,  4'd4, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 1, 0,   1,  4'd0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd0, 1, 1,   1,  4'd0, 0, 0, 0, 0);
    add(0, 0, 0, 4'd0, 0, 0,   2,  4'd0, 0, 0, 0, 0);
    add(0, 0, 0, 4'd0, 0, 1,   1,  4'd0, 0, 0, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd0, 0, 0, 1, 1);
    // redirect mid-ramp: toward 8 at duty 4, new target 2
    add(1, 0, 1, 4'd8, 0, 0,   1,  4'd0, 0, 0, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd0, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  80,  4'd4, 1, 1, 0, 1);
    add(0, 1, 1, 4'd2, 0, 0,   1,  4'd4, 1, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  19,  4'd3, 1, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,  19,  4'd3, 0, 1, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0,   1,  4'd2, 1, 0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      enable    = vecs[i].en;
      tgt_valid = vecs[i].vld;
      tgt_duty  = vecs[i].tgt;
      fault     = vecs[i].flt;
      fault_clr = vecs[i].clr;
      if (vecs[i].ncyc == 0) #2;
      else repeat (vecs[i].ncyc) tick();
      chk($sformatf("v%0d.duty", i),      32'(duty),      32'(vecs[i].e_duty));
      chk($sformatf("v%0d.pwm_out", i),   32'(pwm_out),   32'(vecs[i].e_pwm));
      chk($sformatf("v%0d.busy", i),      32'(busy),      32'(vecs[i].e_busy));
      chk($sformatf("v%0d.at_target", i), 32'(at_target), 32'(vecs[i].e_at));
      chk($sformatf("v%0d.tgt_ready", i), 32'(tgt_ready), 32'(vecs[i].e_rdy));
    end

    // duty 3 gives exactly 3 high cycles per 10-cycle period
    ramp_to(4'd3);
    chk("run3.at_target", 32'(at_target), 32'd1);
    ones = 0;
    for (int k = 0; k < 10; k++) begin
      ones += int'(pwm_out);
      if (k < 9) tick();
    end
    chk("run3.pwm_high_count", 32'(ones), 32'd3);

    // asynchronous reset mid-ramp: outputs drop without a clock edge
    do_reset();
    tgt_valid = 1'b1;
    tgt_duty  = 4'd8;
    tick();
    tgt_valid = 1'b0;
    enable    = 1'b1;
    repeat (83) tick();
    chk("pre_rst.pwm_out", 32'(pwm_out), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst.duty",      32'(duty),      32'd0);
    chk("async_rst.pwm_out",   32'(pwm_out),   32'd0);
    chk("async_rst.busy",      32'(busy),      32'd0);
    chk("async_rst.at_target", 32'(at_target), 32'd0);
    chk("async_rst.tgt_ready", 32'(tgt_ready), 32'd1);
    ones = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      ones += int'(pwm_out) + int'(busy);
    end
    chk("held_rst.activity", 32'(ones), 32'd0);
    reset_n = 1'b1;
    tick();
    // tgt_q was cleared by reset, so enable goes straight to RUN at duty 0
    chk("post_rst.at_target", 32'(at_target), 32'd1);
    chk("post_rst.duty",      32'(duty),      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
